// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_if
// Description : Bundle of the decode-side offer, the execute-side result and
//               the handshake between them for the ID/EX pipeline register.
//               master : the surrounding pipeline (drives decode fields,
//                        flush and out_ready; observes in_ready and ex_*).
//               slave  : the id_ex_stage register itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
);
  // Decode side
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic            alu_src;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic            funct7_b30;
  logic [RD_W-1:0] rd;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic            mem_to_reg;
  logic            branch;
  // Execute side
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] ex_number_1;
  logic [XLEN-1:0] ex_number_2;
  logic [3:0]      ex_control;
  logic [XLEN-1:0] ex_store_data;
  logic [RD_W-1:0] ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_mem_to_reg;
  logic            ex_branch;
  logic            ex_illegal;

  modport master (
    output flush, in_valid, rs1_data, rs2_data, imm, alu_src, alu_op,
           funct3, funct7_b30, rd, reg_write, mem_read, mem_write,
           mem_to_reg, branch, out_ready,
    input  in_ready, out_valid, ex_number_1, ex_number_2, ex_control,
           ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, ex_branch, ex_illegal
  );

  modport slave (
    input  flush, in_valid, rs1_data, rs2_data, imm, alu_src, alu_op,
           funct3, funct7_b30, rd, reg_write, mem_read, mem_write,
           mem_to_reg, branch, out_ready,
    output in_ready, out_valid, ex_number_1, ex_number_2, ex_control,
           ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, ex_branch, ex_illegal
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register in front of a 64-bit ALU. Captures
//               operands and control bits, selects ALU operand 2, decodes
//               and registers the 4-bit ALU control code. Valid/ready
//               handshake for stalls, synchronous flush for mispredicts.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - id_ex_stage_if.slave (decode offer, handshake,
//                       flush, registered ex_* results)
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  id_ex_stage_if.slave  bus
);

  localparam logic [3:0] C_CTRL_AND = 4'b0000;
  localparam logic [3:0] C_CTRL_OR  = 4'b0001;
  localparam logic [3:0] C_CTRL_ADD = 4'b0010;
  localparam logic [3:0] C_CTRL_SUB = 4'b0110;

  logic            r_valid;
  logic [XLEN-1:0] r_number_1;
  logic [XLEN-1:0] r_number_2;
  logic [XLEN-1:0] r_store_data;
  logic [3:0]      r_control;
  logic [RD_W-1:0] r_rd;
  logic            r_reg_write;
  logic            r_mem_read;
  logic            r_mem_write;
  logic            r_mem_to_reg;
  logic            r_branch;
  logic            r_illegal;

  logic            w_in_ready;
  logic            w_accept;
  logic [XLEN-1:0] w_op2;
  logic [3:0]      w_control;
  logic            w_illegal;

  // in_ready looks only at the output side so no in_* -> in_ready loop exists.
  assign w_in_ready = !r_valid || bus.out_ready;
  // A flush kills the offered instruction even though in_ready stays high.
  assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;
  assign w_op2      = bus.alu_src ? bus.imm : bus.rs2_data;

  always_comb begin
    w_control = C_CTRL_ADD;
    w_illegal = 1'b0;
    case (bus.alu_op)
      2'b00: w_control = C_CTRL_ADD;
      2'b01: w_control = C_CTRL_SUB;
      2'b10: begin
        case (bus.funct3)
          3'b000:  w_control = bus.funct7_b30 ? C_CTRL_SUB : C_CTRL_ADD;
          3'b111:  w_control = C_CTRL_AND;
          3'b110:  w_control = C_CTRL_OR;
          default: w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Control bits are cleared whenever the entry leaves without replacement,
  // so a bubble never carries side effects. Operands simply hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_number_1   <= '0;
      r_number_2   <= '0;
      r_store_data <= '0;
      r_control    <= C_CTRL_ADD;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_branch     <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (bus.flush || (r_valid && bus.out_ready && !w_accept)) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_branch     <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (w_accept) begin
      r_valid      <= 1'b1;
      r_number_1   <= bus.rs1_data;
      r_number_2   <= w_op2;
      r_store_data <= bus.rs2_data;
      r_control    <= w_control;
      r_rd         <= bus.rd;
      // An illegal decode must not write anything or redirect control flow.
      r_reg_write  <= bus.reg_write && !w_illegal;
      r_mem_read   <= bus.mem_read  && !w_illegal;
      r_mem_write  <= bus.mem_write && !w_illegal;
      r_branch     <= bus.branch    && !w_illegal;
      r_mem_to_reg <= bus.mem_to_reg;
      r_illegal    <= w_illegal;
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = r_valid;
  assign bus.ex_number_1   = r_number_1;
  assign bus.ex_number_2   = r_number_2;
  assign bus.ex_store_data = r_store_data;
  assign bus.ex_control    = r_control;
  assign bus.ex_rd         = r_rd;
  assign bus.ex_reg_write  = r_reg_write;
  assign bus.ex_mem_read   = r_mem_read;
  assign bus.ex_mem_write  = r_mem_write;
  assign bus.ex_mem_to_reg = r_mem_to_reg;
  assign bus.ex_branch     = r_branch;
  assign bus.ex_illegal    = r_illegal;

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between instruction decode and the 64-bit execute-stage ALU.
- Captures decoded operands and control bits, selects the ALU second operand (register or immediate), and registers the 4-bit ALU control code the ALU consumes.
- Uses a valid/ready handshake for stalls, plus a synchronous flush for branch mispredicts.
- Bubbles never carry architectural side effects.

Parameters:
- XLEN, 64, operand/immediate width.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard the held entry and any entry offered this cycle.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- rs1_data  in  XLEN  source operand 1.
- rs2_data  in  XLEN  source operand 2.
- imm  in  XLEN  sign-extended immediate.
- alu_src  in  1  1 selects imm as operand 2.
- alu_op  in  2  00 load/store, 01 branch, 10 R-type, 11 reserved.
- funct3  in  3  instruction funct3.
- funct7_b30  in  1  instruction bit 30.
- rd  in  RD_W  destination index.
- reg_write, mem_read, mem_write, mem_to_reg, branch  in  1 each  decode control bits.
- out_valid  out  1  execute holds a valid entry.
- out_ready  in  1  execute/downstream accepts.
- ex_number_1  out  XLEN  ALU operand 1.
- ex_number_2  out  XLEN  ALU operand 2.
- ex_control  out  4  ALU control code.
- ex_store_data  out  XLEN  registered rs2_data, used for stores.
- ex_rd  out  RD_W  registered rd.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each  registered control bits.
- ex_illegal  out  1  unsupported alu_op/funct combination.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs go to 0, except ex_control = 4'b0010 (add).
  - in_ready reads 1 once out_valid is 0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer occurs when in_valid && in_ready. Latency is 1 cycle: captured data appears on the ex_* outputs the next cycle, with out_valid=1.
  - If out_valid && out_ready && !(in_valid && in_ready), out_valid clears next cycle.
  - If out_valid && !out_ready, all ex_* outputs hold bit-stable.
- Operand 2 mux: ex_number_2 = alu_src ? imm : rs2_data, selected at capture. ex_number_1 = rs1_data.
- ALU control decode, registered at capture:
  - alu_op=00 -> 0010.
  - alu_op=01 -> 0110.
  - alu_op=10:
    - funct3=000, b30=0 -> 0010.
    - funct3=000, b30=1 -> 0110.
    - funct3=111 -> 0000.
    - funct3=110 -> 0001.
  - Any other combination: ex_illegal=1, ex_control=0010, and ex_reg_write, ex_mem_write, ex_mem_read, ex_branch forced to 0.
- Bubble rule:
  - Whenever out_valid=0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch and ex_illegal read 0.
  - Operand outputs are don't-care but hold their last value (no toggling).
- Flush:
  - A synchronous flush forces out_valid=0 next cycle and discards any concurrent in_valid transfer, even when in_ready=1.
  - in_ready is unaffected by flush.
  - Flush together with out_ready: the held entry is dropped regardless.
- Simultaneous accept/deliver: when out_valid && out_ready && in_valid, the new entry replaces the old one in the same edge, giving full throughput of 1 instruction/cycle.
- Reset mid-stall: an asserted rst_n low clears out_valid immediately, independent of clk.
- No combinational path from in_* data to ex_* outputs. in_ready depends only on out_valid and out_ready.

Test Plan:
- Reset then single R-type add:
  - Stimulus: rs1=64'h5, rs2=64'h3, alu_op=10, funct3=000, b30=0, alu_src=0.
  - Required: the next cycle shows out_valid=1, ex_control=0010, ex_number_2=3, ex_reg_write=1.
- Immediate load path:
  - Stimulus: alu_op=00, alu_src=1, imm=64'hFFFF_FFFF_FFFF_FFF8, rs2=64'h77.
  - Required: ex_number_2=...FFF8, ex_store_data=64'h77, ex_control=0010.
- Stall:
  - Stimulus: out_ready=0 for 3 cycles with back-to-back in_valid.
  - Required: in_ready=0, ex_* outputs bit-stable for 3 cycles. On out_ready=1, the next instruction (sub, b30=1) appears the following cycle with ex_control=0110.
- Flush:
  - Stimulus: flush=1 in the same cycle as a valid branch transfer (alu_op=01).
  - Required: out_valid=0 next cycle, ex_branch=0.
- Illegal decode:
  - Stimulus: alu_op=10, funct3=001, reg_write=1.
  - Required: ex_illegal=1, ex_reg_write=0, ex_control=0010. Also run alu_op=11 and check the same response.
- Asynchronous reset mid-stall:
  - Stimulus: drop rst_n between clock edges while out_valid=1 and out_ready=0.
  - Required: out_valid=0 and ex_control=0010 before the next edge; in_ready=1 after release.
